// File: rtl/ps2_key_scanner_if.sv
// Key-event handshake between the PS/2 scanner and the game logic.
// The scanner drives the event head and status; the consumer drives evt_ready.
interface ps2_key_scanner_if;
   logic [9:0] evt_data;
   logic       evt_valid;
   logic       evt_ready;
   logic       evt_overflow;

   modport master (
      output evt_data,
      output evt_valid,
      output evt_overflow,
      input  evt_ready
   );

   modport slave (
      input  evt_data,
      input  evt_valid,
      input  evt_overflow,
      output evt_ready
   );
endinterface

// File: rtl/ps2_key_scanner.sv
// PS/2 keyboard receiver: frame checking, E0/F0 decode and a held-key table.
// Define PS2_EVENT_FIFO_EN to queue every key event for the game logic.
module ps2_key_scanner #(
   parameter int                    NUM_KEYS       = 10,
   parameter logic [9*NUM_KEYS-1:0] KEY_MAP        = {9'h05A, 9'h029, 9'h023, 9'h01B, 9'h01C,
                                                      9'h01D, 9'h174, 9'h16B, 9'h172, 9'h175},
   parameter int                    TIMEOUT_CYCLES = 50000,
   parameter int                    FIFO_DEPTH     = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ps2_clk_i,
   input  logic                ps2_data_i,
   output logic [NUM_KEYS-1:0] key_state_o,
   output logic [NUM_KEYS-1:0] key_press_o,
   output logic [NUM_KEYS-1:0] key_release_o,
   output logic                frame_err_o,
   ps2_key_scanner_if.master   evt
);

   localparam int WdW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frameState_t;

   logic             clkMeta_q, clkSync_q, clkPrev_q;
   logic             dataMeta_q, dataSync_q;
   logic             fall;
   frameState_t      state_q;
   logic [7:0]       shift_q;
   logic [2:0]       bitCnt_q;
   logic [WdW-1:0]   wdog_q;
   logic             frameErr_q;
   logic             byteValid_q;
   logic [7:0]       rxByte_q;
   logic             ext_q, brk_q;
   logic             evtStb_q;
   logic [9:0]       evtData_q;
   logic             isDiscard;

   // Lines idle high, so the synchronisers reset to 1 to avoid a false edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         clkMeta_q  <= 1'b1;
         clkSync_q  <= 1'b1;
         clkPrev_q  <= 1'b1;
         dataMeta_q <= 1'b1;
         dataSync_q <= 1'b1;
      end else begin
         clkMeta_q  <= ps2_clk_i;
         clkSync_q  <= clkMeta_q;
         clkPrev_q  <= clkSync_q;
         dataMeta_q <= ps2_data_i;
         dataSync_q <= dataMeta_q;
      end
   end

   assign fall = clkPrev_q & ~clkSync_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         bitCnt_q    <= '0;
         wdog_q      <= '0;
         frameErr_q  <= 1'b0;
         byteValid_q <= 1'b0;
         rxByte_q    <= '0;
      end else begin
         frameErr_q  <= 1'b0;
         byteValid_q <= 1'b0;
         if (state_q == IDLE || fall) wdog_q <= '0;
         else                         wdog_q <= wdog_q + WdW'(1);

         if (state_q != IDLE && wdog_q == WdW'(TIMEOUT_CYCLES)) begin
            state_q    <= IDLE;
            frameErr_q <= 1'b1;
         end else if (fall) begin
            case (state_q)
               IDLE: begin
                  if (!dataSync_q) begin
                     state_q  <= DATA;
                     bitCnt_q <= '0;
                  end
               end
               DATA: begin
                  shift_q  <= {dataSync_q, shift_q[7:1]};
                  bitCnt_q <= bitCnt_q + 3'd1;
                  if (bitCnt_q == 3'd7) state_q <= PARITY;
               end
               PARITY: begin
                  if (^{shift_q, dataSync_q}) begin
                     state_q <= STOP;
                  end else begin
                     state_q    <= IDLE;
                     frameErr_q <= 1'b1;
                  end
               end
               STOP: begin
                  state_q <= IDLE;
                  if (dataSync_q) begin
                     byteValid_q <= 1'b1;
                     rxByte_q    <= shift_q;
                  end else begin
                     frameErr_q <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   always_comb begin
      isDiscard = 1'b0;
      case (rxByte_q)
         8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1: isDiscard = 1'b1;
         default:                                          isDiscard = 1'b0;
      endcase
   end

   // Prefix tracking and the key table; a rejected frame also drops any pending prefix.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ext_q         <= 1'b0;
         brk_q         <= 1'b0;
         evtStb_q      <= 1'b0;
         evtData_q     <= '0;
         key_state_o   <= '0;
         key_press_o   <= '0;
         key_release_o <= '0;
      end else begin
         evtStb_q      <= 1'b0;
         key_press_o   <= '0;
         key_release_o <= '0;
         if (frameErr_q) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
         end else if (byteValid_q) begin
            if (rxByte_q == 8'hE0) begin
               ext_q <= 1'b1;
            end else if (rxByte_q == 8'hF0) begin
               brk_q <= 1'b1;
            end else begin
               ext_q <= 1'b0;
               brk_q <= 1'b0;
               if (!isDiscard) begin
                  evtStb_q  <= 1'b1;
                  evtData_q <= {ext_q, brk_q, rxByte_q};
                  for (int i = 0; i < NUM_KEYS; i++) begin
                     if (KEY_MAP[9*i +: 9] == {ext_q, rxByte_q}) begin
                        key_state_o[i]   <= ~brk_q;
                        key_press_o[i]   <= ~brk_q & ~key_state_o[i];
                        key_release_o[i] <= brk_q & key_state_o[i];
                     end
                  end
               end
            end
         end
      end
   end

   assign frame_err_o = frameErr_q;

`ifdef PS2_EVENT_FIFO_EN
   logic [9:0]    mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wrPtr_q, rdPtr_q;
   logic [PtrW:0]   count_q;
   logic            overflow_q;
   logic            full, pop, pushOk;

   assign full   = (count_q == (PtrW+1)'(FIFO_DEPTH));
   assign pop    = (count_q != '0) && evt.evt_ready;
   assign pushOk = evtStb_q && (!full || pop);

   // On full with a simultaneous pop the write reuses the slot being popped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (pushOk) begin
            mem_q[wrPtr_q] <= evtData_q;
            wrPtr_q        <= wrPtr_q + PtrW'(1);
         end else if (evtStb_q) begin
            overflow_q <= 1'b1;
         end
         if (pop) rdPtr_q <= rdPtr_q + PtrW'(1);
         if (pushOk && !pop)      count_q <= count_q + (PtrW+1)'(1);
         else if (!pushOk && pop) count_q <= count_q - (PtrW+1)'(1);
      end
   end

   assign evt.evt_data     = mem_q[rdPtr_q];
   assign evt.evt_valid    = (count_q != '0);
   assign evt.evt_overflow = overflow_q;
`else
   logic          unusedEvt;
   logic [PtrW:0] unusedLevel;

   assign unusedEvt        = ^{evt.evt_ready, evtStb_q, evtData_q};
   assign unusedLevel      = '0;
   assign evt.evt_data     = '0;
   assign evt.evt_valid    = 1'b0;
   assign evt.evt_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_key_scanner.sv
// Directed bench for ps2_key_scanner: serial PS/2 frames with hand-computed key table results.
// The event-queue section is active when PS2_EVENT_FIFO_EN is defined for the build.
module tb_ps2_key_scanner;

   localparam int HALF    = 20;
   localparam int TIMEOUT = 300;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ps2Clk = 1'b1;
   logic       ps2Data = 1'b1;
   logic [9:0] keyState, keyPress, keyRelease;
   logic       frameErr;
   int         checks = 0;
   int         errors = 0;
   int         pressCnt [10];
   int         releaseCnt [10];
   int         errCnt;

   ps2_key_scanner_if evtIf ();

   ps2_key_scanner #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk           (clk),
      .rst           (rst),
      .ps2_clk_i     (ps2Clk),
      .ps2_data_i    (ps2Data),
      .key_state_o   (keyState),
      .key_press_o   (keyPress),
      .key_release_o (keyRelease),
      .frame_err_o   (frameErr),
      .evt           (evtIf)
   );

   always #5 clk = ~clk;

   // Pulse counters, sampled on the falling system-clock edge.
   always @(negedge clk) begin
      for (int i = 0; i < 10; i++) begin
         if (keyPress[i] === 1'b1)   pressCnt[i]++;
         if (keyRelease[i] === 1'b1) releaseCnt[i]++;
      end
      if (frameErr === 1'b1) errCnt++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic clearCounts();
      for (int i = 0; i < 10; i++) begin
         pressCnt[i]   = 0;
         releaseCnt[i] = 0;
      end
      errCnt = 0;
   endtask

   task automatic sendBit(input logic b);
      @(negedge clk);
      ps2Data = b;
      repeat (HALF) @(negedge clk);
      ps2Clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2Clk = 1'b1;
   endtask

   task automatic applyStimulus(input logic [7:0] b, input logic badParity = 1'b0);
      sendBit(1'b0);
      for (int i = 0; i < 8; i++) sendBit(b[i]);
      sendBit(~^b ^ badParity);
      sendBit(1'b1);
      repeat (2*HALF) @(negedge clk);
   endtask

   logic [7:0] fifoCodes [9];

   initial begin
      fifoCodes = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h5A, 8'h15, 8'h24, 8'h2D};
      evtIf.evt_ready = 1'b1;
      clearCounts();
      repeat (5) @(negedge clk);
      checkOutput("reset key_state", 32'(keyState), 32'h0);
      checkOutput("reset frame_err", 32'(frameErr), 32'h0);
      checkOutput("reset evt_valid", 32'(evtIf.evt_valid), 32'h0);
      checkOutput("reset evt_data", 32'(evtIf.evt_data), 32'h0);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      // W (1D) make and break
      applyStimulus(8'h1D);
      checkOutput("1D make state", 32'(keyState), 32'h010);
      checkOutput("1D press count", 32'(pressCnt[4]), 32'd1);
      applyStimulus(8'hF0);
      applyStimulus(8'h1D);
      checkOutput("1D break state", 32'(keyState), 32'h000);
      checkOutput("1D release count", 32'(releaseCnt[4]), 32'd1);
      checkOutput("1D no extra press", 32'(pressCnt[4]), 32'd1);

      // Extended up arrow with typematic repeat
      applyStimulus(8'hE0);
      applyStimulus(8'h75);
      checkOutput("E0 75 state", 32'(keyState), 32'h001);
      applyStimulus(8'hE0);
      applyStimulus(8'h75);
      checkOutput("E0 75 repeat press", 32'(pressCnt[0]), 32'd1);
      applyStimulus(8'h75);
      checkOutput("plain 75 state", 32'(keyState), 32'h001);
      applyStimulus(8'hE0);
      applyStimulus(8'hF0);
      applyStimulus(8'h75);
      checkOutput("E0 F0 75 state", 32'(keyState), 32'h000);
      checkOutput("E0 F0 75 release", 32'(releaseCnt[0]), 32'd1);
      applyStimulus(8'h75);
      checkOutput("plain 75 released", 32'(keyState), 32'h000);

      // Parity error then a good space
      clearCounts();
      applyStimulus(8'h29, 1'b1);
      checkOutput("bad parity err", 32'(errCnt), 32'd1);
      checkOutput("bad parity state", 32'(keyState), 32'h000);
      applyStimulus(8'h29);
      checkOutput("good 29 state", 32'(keyState), 32'h100);
      checkOutput("good 29 no err", 32'(errCnt), 32'd1);

      // Stalled frame recovered by the watchdog
      sendBit(1'b0);
      sendBit(1'b0);
      sendBit(1'b1);
      sendBit(1'b0);
      sendBit(1'b1);
      repeat (TIMEOUT + 60) @(negedge clk);
      checkOutput("timeout err", 32'(errCnt), 32'd2);
      applyStimulus(8'h5A);
      checkOutput("5A after timeout", 32'(keyState), 32'h300);
      checkOutput("5A press", 32'(pressCnt[9]), 32'd1);

`ifdef PS2_EVENT_FIFO_EN
      checkOutput("fifo drained", 32'(evtIf.evt_valid), 32'h0);
      evtIf.evt_ready = 1'b0;
      for (int k = 0; k < 9; k++) applyStimulus(fifoCodes[k]);
      checkOutput("fifo overflow", 32'(evtIf.evt_overflow), 32'h1);
      for (int k = 0; k < 8; k++) begin
         checkOutput($sformatf("fifo valid %0d", k), 32'(evtIf.evt_valid), 32'h1);
         checkOutput($sformatf("fifo data %0d", k), 32'(evtIf.evt_data), {24'h0, 2'b00, fifoCodes[k]});
         evtIf.evt_ready = 1'b1;
         @(negedge clk);
         evtIf.evt_ready = 1'b0;
      end
      checkOutput("fifo empty", 32'(evtIf.evt_valid), 32'h0);
      checkOutput("fifo overflow sticky", 32'(evtIf.evt_overflow), 32'h1);
`else
      checkOutput("no fifo valid", 32'(evtIf.evt_valid), 32'h0);
      checkOutput("no fifo data", 32'(evtIf.evt_data), 32'h0);
      checkOutput("no fifo overflow", 32'(evtIf.evt_overflow), 32'h0);
`endif

      // Reset in the middle of a frame
      sendBit(1'b0);
      sendBit(1'b1);
      sendBit(1'b1);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("midreset key_state", 32'(keyState), 32'h000);
      checkOutput("midreset frame_err", 32'(frameErr), 32'h0);
      checkOutput("midreset evt_valid", 32'(evtIf.evt_valid), 32'h0);
      checkOutput("midreset overflow", 32'(evtIf.evt_overflow), 32'h0);
      rst = 1'b1;
      evtIf.evt_ready = 1'b1;
      clearCounts();
      repeat (2*HALF) @(negedge clk);
      applyStimulus(8'h1B);
      checkOutput("1B after reset", 32'(keyState), 32'h040);
      checkOutput("1B press", 32'(pressCnt[6]), 32'd1);
      checkOutput("1B no err", 32'(errCnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
